// File: rtl/addr_region_router_pkg.sv
// Memory map for the ITCM/DTCM/CSR targets, plus the packed default window
// tables and region id type used by the address region router.
package addr_region_router_pkg;

    localparam logic [31:0] ITCM_BASE = 32'h0000_0000;
    localparam logic [31:0] ITCM_LEN  = 32'h0000_2000;
    localparam logic [31:0] DTCM_BASE = 32'h0001_0000;
    localparam logic [31:0] DTCM_LEN  = 32'h0000_8000;
    localparam logic [31:0] CSR_BASE  = 32'h0003_0000;
    localparam logic [31:0] CSR_LEN   = 32'h0001_0000;

    localparam int NUM_DEFAULT_REGIONS = 3;

    // Index 0 sits in the LSBs.
    localparam logic [NUM_DEFAULT_REGIONS*32-1:0] DEFAULT_REGION_BASE = {CSR_BASE, DTCM_BASE, ITCM_BASE};
    localparam logic [NUM_DEFAULT_REGIONS*32-1:0] DEFAULT_REGION_LEN  = {CSR_LEN,  DTCM_LEN,  ITCM_LEN};

    localparam int REGION_ID_W = $clog2(NUM_DEFAULT_REGIONS + 1);
    typedef logic [REGION_ID_W-1:0] region_id_t;
    localparam region_id_t REGION_ERR = region_id_t'(NUM_DEFAULT_REGIONS);

endpackage

// File: rtl/addr_region_router_if.sv
// Initiator request/response stream plus the per-target request/response bundle.
interface addr_region_router_if #(
    parameter int NUM_REGIONS = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    logic                          req_valid_i;
    logic                          req_ready_o;
    logic [ADDR_W-1:0]             req_addr_i;
    logic                          req_we_i;
    logic [DATA_W-1:0]             req_wdata_i;
    logic [DATA_W/8-1:0]           req_be_i;

    logic [NUM_REGIONS-1:0]        tgt_req_valid_o;
    logic [NUM_REGIONS-1:0]        tgt_req_ready_i;
    logic [ADDR_W-1:0]             tgt_req_addr_o;
    logic                          tgt_req_we_o;
    logic [DATA_W-1:0]             tgt_req_wdata_o;
    logic [DATA_W/8-1:0]           tgt_req_be_o;

    logic [NUM_REGIONS-1:0]        tgt_rsp_valid_i;
    logic [NUM_REGIONS-1:0]        tgt_rsp_ready_o;
    logic [NUM_REGIONS*DATA_W-1:0] tgt_rsp_rdata_i;
    logic [NUM_REGIONS-1:0]        tgt_rsp_err_i;

    logic                          rsp_valid_o;
    logic                          rsp_ready_i;
    logic [DATA_W-1:0]             rsp_rdata_o;
    logic                          rsp_err_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i,
        output req_ready_o,
        output tgt_req_valid_o, tgt_req_addr_o, tgt_req_we_o, tgt_req_wdata_o, tgt_req_be_o,
        input  tgt_req_ready_i,
        input  tgt_rsp_valid_i, tgt_rsp_rdata_i, tgt_rsp_err_i,
        output tgt_rsp_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i
    );

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_be_i,
        input  req_ready_o,
        input  tgt_req_valid_o, tgt_req_addr_o, tgt_req_we_o, tgt_req_wdata_o, tgt_req_be_o,
        output tgt_req_ready_i,
        output tgt_rsp_valid_i, tgt_rsp_rdata_i, tgt_rsp_err_i,
        input  tgt_rsp_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/router_order_fifo.sv
// Synchronous FIFO recording the target id of each outstanding request, so
// responses can be returned to the initiator in request order.
module router_order_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic [PTR_W:0]     r_count;
    logic               w_push, w_pop;

    assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign head_o  = r_mem[r_rptr];
    assign count_o = r_count;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/addr_region_router.sv
// Decodes one request stream onto NUM_REGIONS base/length windows, answers
// unmapped addresses internally, and returns responses in request order.
module addr_region_router
    import addr_region_router_pkg::*;
#(
    parameter int NUM_REGIONS     = NUM_DEFAULT_REGIONS,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEFAULT_REGION_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LEN  = DEFAULT_REGION_LEN
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    addr_region_router_if.slave                bus,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic [15:0]                        decerr_count_o
);
    localparam int ID_W = $clog2(NUM_REGIONS + 1);
    localparam logic [ID_W-1:0] ERR_ID = ID_W'(NUM_REGIONS);

    if (NUM_REGIONS < 1 || NUM_REGIONS > 8) begin : g_bad_regions
        $error("addr_region_router: NUM_REGIONS must be in 1..8");
    end
    if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_depth
        $error("addr_region_router: MAX_OUTSTANDING must be a power of 2 >= 2");
    end

    logic [NUM_REGIONS-1:0] w_hit, w_sel_oh, w_head_oh;
    logic [ID_W-1:0]        w_sel, w_head;
    logic                   w_full, w_empty, w_push, w_pop, w_head_err, w_rsp_valid;
    logic [DATA_W-1:0]      w_rdata;
    logic [15:0]            r_decerr;

    // Window end is formed in ADDR_W+1 bits so a window touching the top of
    // the address space does not wrap to zero.
    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_dec
        logic [ADDR_W:0] w_lo, w_hi, w_addr;
        assign w_lo      = {1'b0, REGION_BASE[g*ADDR_W +: ADDR_W]};
        assign w_hi      = w_lo + {1'b0, REGION_LEN[g*ADDR_W +: ADDR_W]};
        assign w_addr    = {1'b0, bus.req_addr_i};
        assign w_hit[g]  = (REGION_LEN[g*ADDR_W +: ADDR_W] != '0) && (w_addr >= w_lo) && (w_addr < w_hi);
        assign w_head_oh[g] = ~w_empty && (w_head == ID_W'(g));
    end

    // Scan high to low so the lowest matching index is the one that sticks.
    always_comb begin
        w_sel    = ERR_ID;
        w_sel_oh = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel    = ID_W'(i);
                w_sel_oh = NUM_REGIONS'(1) << i;
            end
        end
    end

    assign bus.tgt_req_valid_o = w_sel_oh & {NUM_REGIONS{bus.req_valid_i & ~w_full}};
    assign bus.req_ready_o     = ~w_full & ((w_sel == ERR_ID) | (|(bus.tgt_req_ready_i & w_sel_oh)));
    assign bus.tgt_req_addr_o  = bus.req_addr_i;
    assign bus.tgt_req_we_o    = bus.req_we_i;
    assign bus.tgt_req_wdata_o = bus.req_wdata_i;
    assign bus.tgt_req_be_o    = bus.req_be_i;
    assign w_push              = bus.req_valid_i & bus.req_ready_o;

    router_order_fifo #(.DEPTH(MAX_OUTSTANDING), .W(ID_W)) u_order_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (w_sel),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .count_o (outstanding_o),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (w_head_oh[i]) w_rdata = bus.tgt_rsp_rdata_i[i*DATA_W +: DATA_W];
        end
    end

    // Only the head target sees ready; later targets hold their responses.
    assign w_head_err          = ~w_empty && (w_head == ERR_ID);
    assign w_rsp_valid         = w_head_err | (|(bus.tgt_rsp_valid_i & w_head_oh));
    assign bus.rsp_valid_o     = w_rsp_valid;
    assign bus.rsp_rdata_o     = w_rdata;
    assign bus.rsp_err_o       = w_head_err | (|(bus.tgt_rsp_err_i & w_head_oh));
    assign bus.tgt_rsp_ready_o = w_head_oh & {NUM_REGIONS{bus.rsp_ready_i}};
    assign w_pop               = w_rsp_valid & bus.rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                         r_decerr <= '0;
        else if (w_pop && w_head_err && r_decerr != 16'hFFFF) r_decerr <= r_decerr + 16'd1;
    end
    assign decerr_count_o = r_decerr;

endmodule

// File: tb/tb_addr_region_router.sv
// Scoreboard bench: bench acts as initiator and as the three targets, and
// checks in-order responses, decode errors, full back-pressure and reset.
module tb_addr_region_router;
    import addr_region_router_pkg::*;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [$clog2(MO):0] outstanding;
    logic [15:0]         decerr;

    addr_region_router_if #(.NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    addr_region_router #(
        .NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO),
        .REGION_BASE(DEFAULT_REGION_BASE), .REGION_LEN(DEFAULT_REGION_LEN)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .bus            (bus.slave),
        .outstanding_o  (outstanding),
        .decerr_count_o (decerr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] tq [NR][$];     // per-target pending read data
    logic [DW:0]   sb [$];         // expected {rdata, err} in request order
    logic [NR-1:0] rsp_en = '1;
    logic [NR-1:0] r_hs = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor and target handshake sampling, away from the active edge.
    always @(negedge clk_i) begin
        logic [DW:0] e;
        r_hs = bus.tgt_rsp_valid_i & bus.tgt_rsp_ready_o;
        if (rst_ni && bus.rsp_valid_o && bus.rsp_ready_i) begin
            if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
            else begin
                e = sb.pop_front();
                chk("rsp_rdata", bus.rsp_rdata_o, e[DW:1]);
                chk("rsp_err", bus.rsp_err_o, e[0]);
            end
        end
    end

    // Target model: presents the oldest pending read when enabled.
    always @(posedge clk_i) begin
        #2;
        for (int t = 0; t < NR; t++) begin
            if (r_hs[t] && tq[t].size() > 0) void'(tq[t].pop_front());
            bus.tgt_rsp_valid_i[t]            = rsp_en[t] && (tq[t].size() > 0);
            bus.tgt_rsp_rdata_i[t*DW +: DW]   = (tq[t].size() > 0) ? tq[t][0] : '0;
            bus.tgt_rsp_err_i[t]              = 1'b0;
        end
    end

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [NR-1:0] exp_oh, output int waited);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        bus.req_we_i    = 1'b0;
        bus.req_wdata_i = data;
        bus.req_be_i    = '1;
        waited = 0;
        @(negedge clk_i);
        while (!bus.req_ready_o && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        chk("req_accept", bus.req_ready_o, 1'b1);
        chk("tgt_req_valid", bus.tgt_req_valid_o, exp_oh);
        if (bus.req_ready_o) begin
            if (exp_oh == '0) sb.push_back({{DW{1'b0}}, 1'b1});
            else              sb.push_back({data, 1'b0});
            for (int t = 0; t < NR; t++) if (exp_oh[t]) tq[t].push_back(data);
        end
        @(posedge clk_i); #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk_i);
            k++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        int w;
        bus.req_valid_i     = 1'b0;
        bus.req_addr_i      = '0;
        bus.req_we_i        = 1'b0;
        bus.req_wdata_i     = '0;
        bus.req_be_i        = '0;
        bus.rsp_ready_i     = 1'b0;
        bus.tgt_req_ready_i = '1;

        // Reset state
        @(negedge clk_i);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_decerr", decerr, 0);
        chk("rst_req_ready", bus.req_ready_o, 1);
        chk("rst_tgt_rsp_ready", bus.tgt_rsp_ready_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        bus.rsp_ready_i = 1'b1;

        // Window edges, one per target
        send(32'h0000_1FFC, 32'h1111_0001, 3'b001, w);
        send(32'h0001_7FFC, 32'h2222_0002, 3'b010, w);
        send(32'h0003_FFFF, 32'h3333_0003, 3'b100, w);
        drain();

        // Decode errors just past ITCM and in the hole between DTCM and CSR
        send(32'h0000_2000, 32'hDEAD_0000, 3'b000, w);
        @(negedge clk_i);
        chk("decerr_vld1", bus.rsp_valid_o, 1);
        chk("decerr_err1", bus.rsp_err_o, 1);
        chk("decerr_data1", bus.rsp_rdata_o, 0);
        @(posedge clk_i); #1;
        send(32'h0002_0000, 32'hDEAD_0001, 3'b000, w);
        @(negedge clk_i);
        chk("decerr_vld2", bus.rsp_valid_o, 1);
        chk("decerr_err2", bus.rsp_err_o, 1);
        @(posedge clk_i); #1;
        drain();
        chk("decerr_count", decerr, 2);

        // Out-of-order target responses held until they reach the head
        rsp_en = 3'b011;
        send(32'h0003_0000, 32'h0000_5555, 3'b100, w);
        send(32'h0000_0000, 32'h0000_AAAA, 3'b001, w);
        repeat (2) begin
            @(negedge clk_i);
            chk("itcm_rsp_valid", bus.tgt_rsp_valid_i[0], 1);
            chk("itcm_rsp_held", bus.tgt_rsp_ready_o[0], 0);
        end
        @(posedge clk_i); #1;
        rsp_en = 3'b111;
        drain();

        // Fill the order FIFO, then release one entry
        rsp_en = 3'b011;
        for (int k = 0; k < MO; k++)
            send(32'h0003_0000 + AW'(4*k), 32'hC000_0000 + DW'(k), 3'b100, w);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0003_0010;
        bus.req_wdata_i = 32'hC000_0004;
        @(negedge clk_i);
        chk("full_outstanding", outstanding, MO);
        chk("full_req_ready", bus.req_ready_o, 0);
        chk("full_tgt_valid", bus.tgt_req_valid_o, 0);
        @(posedge clk_i); #1;
        rsp_en = 3'b111;
        @(negedge clk_i);
        chk("full_pop_vld", bus.rsp_valid_o, 1);
        chk("full_pop_ready", bus.req_ready_o, 0);
        @(posedge clk_i); #1;
        send(32'h0003_0010, 32'hC000_0004, 3'b100, w);
        chk("fifth_next_cycle", w, 0);
        drain();

        // Push and pop in the same cycle at count 1
        send(32'h0001_0000, 32'h0D0D_0001, 3'b010, w);
        send(32'h0000_0004, 32'h0D0D_0002, 3'b001, w);
        @(negedge clk_i);
        chk("pushpop_outstanding", outstanding, 1);
        @(posedge clk_i); #1;
        drain();

        // Asynchronous reset with three outstanding
        bus.rsp_ready_i = 1'b0;
        rsp_en = 3'b000;
        send(32'h0002_0000, 32'h0, 3'b000, w);
        send(32'h0001_0004, 32'h7777_0001, 3'b010, w);
        send(32'h0001_0008, 32'h7777_0002, 3'b010, w);
        @(negedge clk_i);
        chk("pre_rst_outstanding", outstanding, 3);
        chk("pre_rst_rsp_valid", bus.rsp_valid_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_outstanding", outstanding, 0);
        chk("async_rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("async_rst_decerr", decerr, 0);
        sb.delete();
        for (int t = 0; t < NR; t++) tq[t].delete();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        bus.rsp_ready_i = 1'b1;
        rsp_en = 3'b111;
        send(32'h0001_0000, 32'hBEEF_0001, 3'b010, w);
        drain();
        chk("post_rst_outstanding", outstanding, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
